// File: rtl/ram_1p_arbiter_if.sv
// Single-port SRAM request/grant/rvalid bus.
// The master issues requests; the slave grants them and returns read data.
interface ram_1p_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            req;
  logic            we;
  logic [DW/8-1:0] be;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic            gnt;
  logic            rvalid;
  logic [DW-1:0]   rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_1p_arbiter.sv
// Two-port arbiter in front of a single-port SRAM, one transaction in flight at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; otherwise port A has fixed priority.
module ram_1p_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic               clk_sys,
  input  logic               rst_sys_n,
  ram_1p_arbiter_if.slave    a_if,
  ram_1p_arbiter_if.slave    b_if,
  ram_1p_arbiter_if.master   mem_if,
  output logic               err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;   // 0 = port A, 1 = port B
  logic            we_q, we_d;
  logic [DW/8-1:0] be_q, be_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            err_q, err_d;

  logic            win_b;
  logic            owner_req;
  logic            a_gnt, b_gnt, a_rvalid, b_rvalid;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_q = 1 means port B takes the next contended arbitration
  logic rr_q, rr_d;

  always_comb begin
    win_b = b_if.req & (~a_if.req | rr_q);
    rr_d  = rr_q;
    if ((state_q == ST_IDLE) && (a_if.req || b_if.req)) begin
      rr_d = ~win_b;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  always_comb begin
    win_b = b_if.req & ~a_if.req;
  end
`endif

  assign owner_req = owner_q ? b_if.req : a_if.req;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    a_rvalid = 1'b0;
    b_rvalid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_if.gnt || mem_if.rvalid) begin
          err_d = 1'b1;
        end
        if (a_if.req || b_if.req) begin
          owner_d = win_b;
          we_d    = win_b ? b_if.we    : a_if.we;
          be_d    = win_b ? b_if.be    : a_if.be;
          addr_d  = win_b ? b_if.addr  : a_if.addr;
          wdata_d = win_b ? b_if.wdata : a_if.wdata;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Abandoned request still completes from the latched fields.
        if (!owner_req || mem_if.rvalid) begin
          err_d = 1'b1;
        end
        if (mem_if.gnt) begin
          a_gnt   = ~owner_q;
          b_gnt   = owner_q;
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        if (mem_if.gnt) begin
          err_d = 1'b1;
        end
        if (mem_if.rvalid) begin
          a_rvalid = ~owner_q;
          b_rvalid = owner_q;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_if.req   = (state_q == ST_REQ);
  assign mem_if.we    = we_q;
  assign mem_if.be    = be_q;
  assign mem_if.addr  = addr_q;
  assign mem_if.wdata = wdata_q;

  assign a_if.gnt     = a_gnt;
  assign b_if.gnt     = b_gnt;
  assign a_if.rvalid  = a_rvalid;
  assign b_if.rvalid  = b_rvalid;
  assign a_if.rdata   = mem_if.rdata;
  assign b_if.rdata   = mem_if.rdata;

  assign err_o        = err_q;

endmodule

// File: tb/tb_ram_1p_arbiter.sv
// Directed self-checking bench for ram_1p_arbiter; expected arbitration order
// follows ARB_ROUND_ROBIN_EN when it is defined.
module tb_ram_1p_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic rst_n;
  logic err;
  int   n_cmp;
  int   n_mis;

  ram_1p_arbiter_if #(.AW(AW), .DW(DW)) a_if ();
  ram_1p_arbiter_if #(.AW(AW), .DW(DW)) b_if ();
  ram_1p_arbiter_if #(.AW(AW), .DW(DW)) mem_if ();

  ram_1p_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_sys   (clk),
    .rst_sys_n (rst_n),
    .a_if      (a_if),
    .b_if      (b_if),
    .mem_if    (mem_if),
    .err_o     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory-side responder: waits for mem req, grants after 'waits' cycles, rvalid one cycle later.
  // who_*: 1 = port A, 2 = port B, 3 = both, 0 = none.
  task automatic serve(input int waits, input logic [31:0] rd, output int who_gnt,
                       output int who_rv, output logic [31:0] addr_seen, output logic timeout);
    timeout   = 1'b1;
    who_gnt   = 0;
    who_rv    = 0;
    addr_seen = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (mem_if.req) begin
        timeout = 1'b0;
        break;
      end
    end
    if (!timeout) begin
      addr_seen = mem_if.addr;
      repeat (waits) @(negedge clk);
      mem_if.gnt = 1'b1;
      #1;
      who_gnt = (a_if.gnt ? 1 : 0) + (b_if.gnt ? 2 : 0);
      @(negedge clk);
      mem_if.gnt    = 1'b0;
      mem_if.rvalid = 1'b1;
      mem_if.rdata  = rd;
      #1;
      who_rv = (a_if.rvalid ? 1 : 0) + (b_if.rvalid ? 2 : 0);
      @(negedge clk);
      mem_if.rvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (mem_if.req !== 1'b0) begin n_mis++; $display("FAIL rst_mem_req: got %0h want 0", mem_if.req); end
    n_cmp++; if (mem_if.we !== 1'b0) begin n_mis++; $display("FAIL rst_mem_we: got %0h want 0", mem_if.we); end
    n_cmp++; if (mem_if.be !== 4'h0) begin n_mis++; $display("FAIL rst_mem_be: got %0h want 0", mem_if.be); end
    n_cmp++; if (mem_if.addr !== 32'h0) begin n_mis++; $display("FAIL rst_mem_addr: got %0h want 0", mem_if.addr); end
    n_cmp++; if (mem_if.wdata !== 32'h0) begin n_mis++; $display("FAIL rst_mem_wdata: got %0h want 0", mem_if.wdata); end
    n_cmp++; if ({a_if.gnt, a_if.rvalid, b_if.gnt, b_if.rvalid} !== 4'b0) begin n_mis++; $display("FAIL rst_gnt_rvalid: got %b want 0000", {a_if.gnt, a_if.rvalid, b_if.gnt, b_if.rvalid}); end
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL rst_err: got %0h want 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read_a();
    @(negedge clk);
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.be = 4'hF; a_if.addr = 32'h10; a_if.wdata = '0;
    #1;
    n_cmp++; if (mem_if.req !== 1'b0) begin n_mis++; $display("FAIL rda_req_idle: got %0h want 0", mem_if.req); end
    @(negedge clk);
    #1;
    n_cmp++; if (mem_if.req !== 1'b1) begin n_mis++; $display("FAIL rda_mem_req: got %0h want 1", mem_if.req); end
    n_cmp++; if (mem_if.addr !== 32'h10) begin n_mis++; $display("FAIL rda_mem_addr: got %0h want 10", mem_if.addr); end
    n_cmp++; if (mem_if.we !== 1'b0) begin n_mis++; $display("FAIL rda_mem_we: got %0h want 0", mem_if.we); end
    n_cmp++; if (a_if.gnt !== 1'b0) begin n_mis++; $display("FAIL rda_gnt_wait1: got %0h want 0", a_if.gnt); end
    @(negedge clk);
    #1;
    n_cmp++; if (a_if.gnt !== 1'b0) begin n_mis++; $display("FAIL rda_gnt_wait2: got %0h want 0", a_if.gnt); end
    @(negedge clk);
    mem_if.gnt = 1'b1;
    #1;
    n_cmp++; if (a_if.gnt !== 1'b1) begin n_mis++; $display("FAIL rda_a_gnt: got %0h want 1", a_if.gnt); end
    n_cmp++; if (b_if.gnt !== 1'b0) begin n_mis++; $display("FAIL rda_b_gnt: got %0h want 0", b_if.gnt); end
    @(negedge clk);
    mem_if.gnt = 1'b0; a_if.req = 1'b0;
    mem_if.rvalid = 1'b1; mem_if.rdata = 32'hDEADBEEF;
    #1;
    n_cmp++; if (mem_if.req !== 1'b0) begin n_mis++; $display("FAIL rda_req_drop: got %0h want 0", mem_if.req); end
    n_cmp++; if (a_if.gnt !== 1'b0) begin n_mis++; $display("FAIL rda_gnt_once: got %0h want 0", a_if.gnt); end
    n_cmp++; if (a_if.rvalid !== 1'b1) begin n_mis++; $display("FAIL rda_a_rvalid: got %0h want 1", a_if.rvalid); end
    n_cmp++; if (a_if.rdata !== 32'hDEADBEEF) begin n_mis++; $display("FAIL rda_a_rdata: got %0h want deadbeef", a_if.rdata); end
    n_cmp++; if (b_if.rvalid !== 1'b0) begin n_mis++; $display("FAIL rda_b_rvalid: got %0h want 0", b_if.rvalid); end
    @(negedge clk);
    mem_if.rvalid = 1'b0;
    #1;
    n_cmp++; if (a_if.rvalid !== 1'b0) begin n_mis++; $display("FAIL rda_rvalid_end: got %0h want 0", a_if.rvalid); end
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL rda_err: got %0h want 0", err); end
  endtask

  task automatic test_write_b();
    @(negedge clk);
    b_if.req = 1'b1; b_if.we = 1'b1; b_if.be = 4'b0011; b_if.addr = 32'h20; b_if.wdata = 32'h1234;
    @(negedge clk);
    mem_if.gnt = 1'b1;
    #1;
    n_cmp++; if (mem_if.req !== 1'b1) begin n_mis++; $display("FAIL wrb_mem_req: got %0h want 1", mem_if.req); end
    n_cmp++; if (mem_if.we !== 1'b1) begin n_mis++; $display("FAIL wrb_mem_we: got %0h want 1", mem_if.we); end
    n_cmp++; if (mem_if.be !== 4'b0011) begin n_mis++; $display("FAIL wrb_mem_be: got %b want 0011", mem_if.be); end
    n_cmp++; if (mem_if.addr !== 32'h20) begin n_mis++; $display("FAIL wrb_mem_addr: got %0h want 20", mem_if.addr); end
    n_cmp++; if (mem_if.wdata !== 32'h1234) begin n_mis++; $display("FAIL wrb_mem_wdata: got %0h want 1234", mem_if.wdata); end
    n_cmp++; if (b_if.gnt !== 1'b1) begin n_mis++; $display("FAIL wrb_b_gnt: got %0h want 1", b_if.gnt); end
    n_cmp++; if (a_if.gnt !== 1'b0) begin n_mis++; $display("FAIL wrb_a_gnt: got %0h want 0", a_if.gnt); end
    @(negedge clk);
    mem_if.gnt = 1'b0; b_if.req = 1'b0; b_if.we = 1'b0;
    mem_if.rvalid = 1'b1; mem_if.rdata = 32'h0;
    #1;
    n_cmp++; if (b_if.rvalid !== 1'b1) begin n_mis++; $display("FAIL wrb_b_rvalid: got %0h want 1", b_if.rvalid); end
    n_cmp++; if (a_if.rvalid !== 1'b0) begin n_mis++; $display("FAIL wrb_a_rvalid: got %0h want 0", a_if.rvalid); end
    @(negedge clk);
    mem_if.rvalid = 1'b0;
  endtask

  task automatic test_contention();
    int          exp_who [8];
    int          g, r, na, nb;
    logic [31:0] ad;
    logic        to;
`ifdef ARB_ROUND_ROBIN_EN
    exp_who = '{1, 2, 1, 2, 1, 2, 1, 2};
`else
    exp_who = '{1, 1, 1, 1, 2, 2, 2, 2};
`endif
    na = 0;
    nb = 0;
    @(negedge clk);
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 32'hA0;
    b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 32'hB0;
    for (int i = 0; i < 8; i++) begin
      serve(0, 32'h100 + i, g, r, ad, to);
      n_cmp++; if (to || g != exp_who[i]) begin n_mis++; $display("FAIL arb_gnt[%0d]: got %0d want %0d (timeout %0b)", i, g, exp_who[i], to); end
      n_cmp++; if (r != exp_who[i]) begin n_mis++; $display("FAIL arb_rvalid[%0d]: got %0d want %0d", i, r, exp_who[i]); end
      n_cmp++; if (ad !== ((exp_who[i] == 1) ? 32'hA0 : 32'hB0)) begin n_mis++; $display("FAIL arb_addr[%0d]: got %0h", i, ad); end
      if (g == 1) na++;
      if (g == 2) nb++;
      if (na >= 4) a_if.req = 1'b0;
      if (nb >= 4) b_if.req = 1'b0;
    end
    a_if.req = 1'b0;
    b_if.req = 1'b0;
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL arb_err: got %0h want 0", err); end
  endtask

  task automatic test_rvalid_in_req();
    @(negedge clk);
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 32'h30;
    @(negedge clk);
    mem_if.rvalid = 1'b1;
    #1;
    n_cmp++; if (mem_if.req !== 1'b1) begin n_mis++; $display("FAIL rvq_mem_req: got %0h want 1", mem_if.req); end
    n_cmp++; if (a_if.rvalid !== 1'b0) begin n_mis++; $display("FAIL rvq_not_fwd: got %0h want 0", a_if.rvalid); end
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL rvq_err_before: got %0h want 0", err); end
    @(negedge clk);
    mem_if.rvalid = 1'b0;
    mem_if.gnt = 1'b1;
    #1;
    n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL rvq_err_set: got %0h want 1", err); end
    n_cmp++; if (a_if.gnt !== 1'b1) begin n_mis++; $display("FAIL rvq_a_gnt: got %0h want 1", a_if.gnt); end
    @(negedge clk);
    mem_if.gnt = 1'b0; a_if.req = 1'b0;
    mem_if.rvalid = 1'b1;
    #1;
    n_cmp++; if (a_if.rvalid !== 1'b1) begin n_mis++; $display("FAIL rvq_a_rvalid: got %0h want 1", a_if.rvalid); end
    @(negedge clk);
    mem_if.rvalid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL rvq_err_sticky: got %0h want 1", err); end
  endtask

  task automatic test_reset_in_rsp();
    int          g, r;
    logic [31:0] ad;
    logic        to;
    @(negedge clk);
    a_if.req = 1'b1; a_if.we = 1'b1; a_if.be = 4'hF; a_if.addr = 32'h40; a_if.wdata = 32'h55;
    @(negedge clk);
    mem_if.gnt = 1'b1;
    @(negedge clk);
    mem_if.gnt = 1'b0; a_if.req = 1'b0;
    rst_n = 1'b0;
    mem_if.rvalid = 1'b1;
    #1;
    n_cmp++; if (mem_if.req !== 1'b0) begin n_mis++; $display("FAIL rsr_mem_req: got %0h want 0", mem_if.req); end
    n_cmp++; if ({mem_if.we, mem_if.be, mem_if.addr, mem_if.wdata} !== '0) begin n_mis++; $display("FAIL rsr_mem_fields: got we=%0h be=%0h addr=%0h wdata=%0h want 0", mem_if.we, mem_if.be, mem_if.addr, mem_if.wdata); end
    n_cmp++; if ({a_if.gnt, a_if.rvalid, b_if.gnt, b_if.rvalid} !== 4'b0) begin n_mis++; $display("FAIL rsr_gnt_rvalid: got %b want 0000", {a_if.gnt, a_if.rvalid, b_if.gnt, b_if.rvalid}); end
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL rsr_err: got %0h want 0", err); end
    @(negedge clk);
    mem_if.rvalid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 32'h44;
    serve(1, 32'hCAFE0001, g, r, ad, to);
    a_if.req = 1'b0;
    n_cmp++; if (to || g != 1) begin n_mis++; $display("FAIL rsr_after_gnt: got %0d want 1 (timeout %0b)", g, to); end
    n_cmp++; if (r != 1) begin n_mis++; $display("FAIL rsr_after_rvalid: got %0d want 1", r); end
    n_cmp++; if (ad !== 32'h44) begin n_mis++; $display("FAIL rsr_after_addr: got %0h want 44", ad); end
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL rsr_after_err: got %0h want 0", err); end
  endtask

  task automatic test_drop_in_req();
    @(negedge clk);
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 32'h50;
    @(negedge clk);
    #1;
    n_cmp++; if (mem_if.req !== 1'b1) begin n_mis++; $display("FAIL drp_mem_req: got %0h want 1", mem_if.req); end
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL drp_err_before: got %0h want 0", err); end
    a_if.req = 1'b0;
    a_if.addr = 32'h99;
    @(negedge clk);
    #1;
    n_cmp++; if (mem_if.req !== 1'b1) begin n_mis++; $display("FAIL drp_mem_req_held: got %0h want 1", mem_if.req); end
    n_cmp++; if (mem_if.addr !== 32'h50) begin n_mis++; $display("FAIL drp_latched_addr: got %0h want 50", mem_if.addr); end
    n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL drp_err_set: got %0h want 1", err); end
    mem_if.gnt = 1'b1;
    #1;
    n_cmp++; if (a_if.gnt !== 1'b1) begin n_mis++; $display("FAIL drp_a_gnt: got %0h want 1", a_if.gnt); end
    @(negedge clk);
    mem_if.gnt = 1'b0;
    mem_if.rvalid = 1'b1; mem_if.rdata = 32'h0000_0505;
    #1;
    n_cmp++; if (a_if.rvalid !== 1'b1) begin n_mis++; $display("FAIL drp_a_rvalid: got %0h want 1", a_if.rvalid); end
    n_cmp++; if (a_if.rdata !== 32'h0000_0505) begin n_mis++; $display("FAIL drp_a_rdata: got %0h want 505", a_if.rdata); end
    @(negedge clk);
    mem_if.rvalid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    a_if.req = 1'b0; a_if.we = 1'b0; a_if.be = '0; a_if.addr = '0; a_if.wdata = '0;
    b_if.req = 1'b0; b_if.we = 1'b0; b_if.be = '0; b_if.addr = '0; b_if.wdata = '0;
    mem_if.gnt = 1'b0; mem_if.rvalid = 1'b0; mem_if.rdata = '0;

    test_reset();
    test_read_a();
    test_write_b();
    test_contention();
    test_rvalid_in_req();
    test_reset_in_rsp();
    test_drop_in_req();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
